// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle MIPS datapath: FSM states, instruction
// fields, mux encodings and ula32 operation codes.
package cpu_pkg;

    typedef enum logic [4:0] {
        ST_RESET = 5'd0,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_IR_LOAD,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WAIT,
        ST_MDR_LOAD,
        ST_WB_LW,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_EXCEPTION
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_EXC    = 2'b11;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_4      = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_SP = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_CONST  = 2'b10;

    localparam logic [2:0] ALU_LOAD = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [31:0] SP_RESET_VAL = 32'd227;
    localparam logic [4:0]  SP_REG       = 5'd29;
    localparam logic [31:0] EXC_VECTOR   = 32'h000000FC;

    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives every
// datapath enable and mux select, including PC load and PC source.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       PC_wr,
    output logic [1:0] pc_src,
    output logic       mem_addr_sel,
    output logic       mem_wr,
    output logic       IR_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       ab_wr,
    output logic       aluout_wr,
    output logic       mdr_wr,
    output logic       epc_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [4:0] state
);

    state_t cur, nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= ST_RESET;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt          = ST_FETCH;
        PC_wr        = 1'b0;
        pc_src       = PC_ALU;
        mem_addr_sel = 1'b0;
        mem_wr       = 1'b0;
        IR_wr        = 1'b0;
        reg_wr       = 1'b0;
        reg_dst      = DST_RT;
        mem_to_reg   = M2R_ALUOUT;
        ab_wr        = 1'b0;
        aluout_wr    = 1'b0;
        mdr_wr       = 1'b0;
        epc_wr       = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = ALUB_B;
        alu_op       = ALU_LOAD;

        case (cur)
            ST_RESET: begin
                reg_wr     = 1'b1;
                reg_dst    = DST_SP;
                mem_to_reg = M2R_CONST;
                nxt        = ST_FETCH;
            end
            ST_FETCH: begin
                alu_src_b = ALUB_4;
                alu_op    = ALU_ADD;
                PC_wr     = 1'b1;
                nxt       = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: nxt = ST_IR_LOAD;
            ST_IR_LOAD: begin
                IR_wr = 1'b1;
                nxt   = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively while A/B load
                ab_wr     = 1'b1;
                aluout_wr = 1'b1;
                alu_src_b = ALUB_IMM_SH;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:      nxt = funct_ok(funct) ? ST_EXEC_R : ST_EXCEPTION;
                    OP_ADDI:       nxt = ST_EXEC_I;
                    OP_LW, OP_SW:  nxt = ST_ADDR;
                    OP_BEQ, OP_BNE: nxt = ST_BRANCH;
                    OP_J:          nxt = ST_JUMP;
                    default:       nxt = ST_EXCEPTION;
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op(funct);
                aluout_wr = 1'b1;
                // A logical AND cannot overflow; the flag is meaningless there
                nxt = (overflow && funct != FN_AND) ? ST_EXCEPTION : ST_WB_R;
            end
            ST_WB_R: begin
                reg_wr  = 1'b1;
                reg_dst = DST_RD;
                nxt     = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_ADD;
                aluout_wr = 1'b1;
                nxt       = overflow ? ST_EXCEPTION : ST_WB_I;
            end
            ST_WB_I: begin
                reg_wr = 1'b1;
                nxt    = ST_FETCH;
            end
            ST_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_ADD;
                aluout_wr = 1'b1;
                nxt       = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_addr_sel = 1'b1;
                nxt          = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: nxt = ST_MDR_LOAD;
            ST_MDR_LOAD: begin
                mdr_wr = 1'b1;
                nxt    = ST_WB_LW;
            end
            ST_WB_LW: begin
                reg_wr     = 1'b1;
                mem_to_reg = M2R_MDR;
                nxt        = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_addr_sel = 1'b1;
                mem_wr       = 1'b1;
                nxt          = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                PC_wr     = (opcode == OP_BNE) ? ~zero : zero;
                nxt       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src = PC_JUMP;
                PC_wr  = 1'b1;
                nxt    = ST_FETCH;
            end
            ST_EXCEPTION: begin
                // PC already advanced in FETCH, so EPC gets PC-4
                alu_src_b = ALUB_4;
                alu_op    = ALU_SUB;
                epc_wr    = 1'b1;
                pc_src    = PC_EXC;
                PC_wr     = 1'b1;
                nxt       = ST_FETCH;
            end
            default: nxt = ST_FETCH;
        endcase

        if (reset) begin
            PC_wr     = 1'b0;
            mem_wr    = 1'b0;
            IR_wr     = 1'b0;
            reg_wr    = 1'b0;
            ab_wr     = 1'b0;
            aluout_wr = 1'b0;
            mdr_wr    = 1'b0;
            epc_wr    = 1'b0;
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle MIPS control FSM for the `cpu` top level. It drives the write enable and source select of the PC register and every other datapath enable and mux select: memory, IR, register file, A/B, ALUOut, MDR, EPC and ALU operation. It sits directly upstream of the PC register and supplies `PC_wr` and the select of the PC source mux. It sequences fetch, decode and execute for a fixed instruction subset and handles two exceptions: invalid instruction and overflow.

## Interface
- Parameters: none. Constants are defined in `cpu_pkg`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ula32 zero flag.
- `overflow`  in  1  ula32 overflow flag.
- `PC_wr`  out  1  PC register load.
- `pc_src`  out  2  PC source select:
  - 00 = ALU result
  - 01 = ALUOut
  - 10 = jump target {PC[31:28], IR[25:0], 00}
  - 11 = exception vector 32'h000000FC
- `mem_addr_sel`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_wr`  out  1  memory write.
- `IR_wr`  out  1  instruction register load.
- `reg_wr`  out  1  register file write.
- `reg_dst`  out  2  write register: 00 = rt, 01 = rd, 10 = 29.
- `mem_to_reg`  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = 227.
- `ab_wr`  out  1  A/B register load.
- `aluout_wr`  out  1  ALUOut load.
- `mdr_wr`  out  1  MDR load.
- `epc_wr`  out  1  EPC load.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B input: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `alu_op`  out  3  ula32 selector: 000 load, 001 add, 010 sub, 011 and.
- `state`  out  5  current state, for debug.

## Operation
- Supported instructions:
  - R-type (opcode 00): add (funct 20), sub (22), and (24).
  - addi (08), lw (23), sw (2B), beq (04), bne (05), j (02).
- Every state not listed below drives all enables to 0 and all selects to 0.
- `RESET`: reg_wr=1, reg_dst=10, mem_to_reg=10, so $29 <- 227. Next state is FETCH.
- `FETCH`: mem_addr_sel=0; PC <- PC+4 (alu_src_a=0, alu_src_b=01, add, pc_src=00, PC_wr=1). Next is FETCH_WAIT.
- `FETCH_WAIT`: idle, covering the synchronous memory read latency. Next is IR_LOAD.
- `IR_LOAD`: IR_wr=1. Next is DECODE.
- `DECODE`:
  - Outputs: ab_wr=1, aluout_wr=1, ALUOut <- PC + sext(imm)<<2.
  - Next state by opcode: R→EXEC_R, addi→EXEC_I, lw/sw→ADDR, beq/bne→BRANCH, j→JUMP.
  - Any other opcode → EXCEPTION.
  - An R-type with unsupported funct also goes to EXCEPTION.
- `EXEC_R`: A op B, with op selected by funct; aluout_wr=1. If overflow (add/sub) go to EXCEPTION, else WB_R.
- `WB_R`: reg_wr=1, reg_dst=01, mem_to_reg=00. Next is FETCH.
- `EXEC_I`: A + sext(imm); aluout_wr=1. If overflow go to EXCEPTION, else WB_I.
- `WB_I`: reg_wr=1, reg_dst=00, mem_to_reg=00. Next is FETCH.
- `ADDR`: A + sext(imm), aluout_wr=1. Next is MEM_RD (lw) or MEM_WR (sw).
- `MEM_RD`: mem_addr_sel=1. Next is MEM_WAIT, then MDR_LOAD (mdr_wr=1), then WB_LW (reg_wr, reg_dst=00, mem_to_reg=01), then FETCH.
- `MEM_WR`: mem_addr_sel=1, mem_wr=1. Next is FETCH.
- `BRANCH`:
  - A − B, pc_src=01.
  - PC_wr = zero for beq, ~zero for bne. This output is combinational on `zero` (Mealy).
  - Next is FETCH.
- `JUMP`: pc_src=10, PC_wr=1. Next is FETCH.
- `EXCEPTION`: EPC <- PC−4 (alu_src_a=0, alu_src_b=01, sub, epc_wr=1); pc_src=11, PC_wr=1. Next is FETCH.
- Overflow is ignored in every state except EXEC_R and EXEC_I.

## Timing
- Reset:
  - Asynchronous assertion forces `state` to RESET at any point, including mid-instruction.
  - While `reset` is high, every write enable is forced to 0.
  - The $29 write happens in the first cycle after release.
- All outputs except the BRANCH `PC_wr` are Moore outputs decoded from the registered state.
- Cycles per instruction, counted from FETCH:
  - R-type and addi: 6.
  - lw: 9.
  - sw: 6.
  - beq/bne and j: 5.
  - Exception: 5 when raised from DECODE, 6 when raised from EXEC.
- On an overflowing add, sub or addi, reg_wr is never asserted for that instruction.
- Selects in enable-free states are don't-care, but must be driven to 0.

## Structure
- `cpu_pkg` holds:
  - the state enum (5 bits);
  - opcode and funct constants;
  - the pc_src, alu_src_b, reg_dst and mem_to_reg encodings;
  - the ula32 op codes;
  - the constants 227, 29 and the exception vector.
- Single module with two blocks: a state register and combinational next-state/output logic. No sub-module.

## Test plan
- Release reset → one cycle of RESET with reg_wr=1, reg_dst=10, mem_to_reg=10; then FETCH with PC_wr=1, pc_src=00, alu_op=001.
- opcode=00, funct=20, overflow=0 → states FETCH, FETCH_WAIT, IR_LOAD, DECODE, EXEC_R, WB_R; reg_wr=1 only in WB_R, with reg_dst=01.
- opcode=23 (lw) → 9-cycle sequence; mdr_wr=1 in MDR_LOAD; WB_LW has mem_to_reg=01.
- opcode=04 (beq):
  - zero=1 → PC_wr=1, pc_src=01 in BRANCH.
  - zero=0 → PC_wr=0.
  - opcode=05 (bne) with zero=0 → PC_wr=1.
- opcode=08 (addi) with overflow=1 in EXEC_I → EXCEPTION with epc_wr=1, pc_src=11, PC_wr=1; reg_wr never asserted.
- opcode=3F → EXCEPTION directly after DECODE. Separately, assert reset during MEM_RD → state is RESET immediately and all enables are 0 while reset is held.
